// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants and fetch-state encoding
package cpu_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INST = 32'h00000013;

  typedef enum logic [1:0] {
    FS_RUN    = 2'd0,
    FS_FROZEN = 2'd1,
    FS_HALT   = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_out_reg.sv
// rtl/if_out_reg.sv - valid/ready fetch output register with flush, load and hold
module if_out_reg #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            en_i,
  input  logic            flush_i,
  input  logic            load_i,
  input  logic            ready_i,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            valid_o,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] pc_o
);
  import cpu_pkg::*;

  logic            valid_q, valid_d;
  logic [31:0]     inst_q, inst_d;
  logic [XLEN-1:0] pc_q, pc_d;

  // Flush only clears valid; contents stay until the next load.
  always_comb begin
    valid_d = valid_q;
    inst_d  = inst_q;
    pc_d    = pc_q;
    if (en_i) begin
      if (flush_i) begin
        valid_d = 1'b0;
      end else if (load_i) begin
        valid_d = 1'b1;
        inst_d  = inst_i;
        pc_d    = pc_i;
      end else if (valid_q && ready_i) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      inst_q  <= NOP_INST;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      inst_q  <= inst_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign inst_o  = inst_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction fetch: PC, ROM addressing, run/freeze/halt control
module if_fetch_stage #(
  parameter int              XLEN       = cpu_pkg::XLEN,
  parameter int              IM_AW      = 6,
  parameter int              PROG_WORDS = 12,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter bit              WRAP       = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             freeze_i,
  input  logic             redir_valid,
  input  logic [XLEN-1:0]  redir_pc,
  output logic [IM_AW-1:0] imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic [XLEN-1:0]  out_pc,
  output logic             halted,
  output logic             misalign_o,
  output logic [XLEN-1:0]  fetch_cnt
);
  import cpu_pkg::*;

  localparam logic [XLEN-1:0] LAST_PC = RESET_PC + XLEN'(4 * (PROG_WORDS - 1));

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] cnt_q, cnt_d;
  logic            mis_q, mis_d;
  logic            fire;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    mis_d   = 1'b0;
    fire    = en && (state_q == FS_RUN) && (!out_valid || out_ready) && !redir_valid;
    if (en) begin
      if (redir_valid) begin
        pc_d    = {redir_pc[XLEN-1:2], 2'b00};
        state_d = freeze_i ? FS_FROZEN : FS_RUN;
        mis_d   = |redir_pc[1:0];
      end else begin
        case (state_q)
          FS_RUN:    if (freeze_i) state_d = FS_FROZEN;
          FS_FROZEN: if (!freeze_i) state_d = FS_RUN;
          default:   state_d = state_q;
        endcase
        // End-of-program halt takes precedence over a freeze raised the same cycle.
        if (fire) begin
          cnt_d = cnt_q + XLEN'(1);
          if (pc_q == LAST_PC) begin
            if (WRAP) pc_d = RESET_PC;
            else      state_d = FS_HALT;
          end else begin
            pc_d = pc_q + XLEN'(4);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= FS_RUN;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
    end
  end

  if_out_reg #(.XLEN(XLEN)) u_out_reg (
    .clk     (clk),
    .rstn    (rstn),
    .en_i    (en),
    .flush_i (redir_valid),
    .load_i  (fire),
    .ready_i (out_ready),
    .inst_i  (imem_rdata),
    .pc_i    (pc_q),
    .valid_o (out_valid),
    .inst_o  (out_inst),
    .pc_o    (out_pc)
  );

  assign imem_addr  = pc_q[IM_AW+1:2];
  assign halted     = (state_q == FS_HALT);
  assign misalign_o = mis_q;
  assign fetch_cnt  = cnt_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - randomized and directed bench for if_fetch_stage (WRAP=1 and WRAP=0)
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rstn, en, freeze_i, redir_valid, out_ready;
  logic [31:0] redir_pc;
  logic [31:0] rom [64];

  logic [5:0]  addr_w, addr_h;
  logic [31:0] rdata_w, rdata_h, inst_w, inst_h, opc_w, opc_h, cnt_w, cnt_h;
  logic        valid_w, valid_h, halt_w, halt_h, mis_w, mis_h;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign rdata_w = rom[addr_w];
  assign rdata_h = rom[addr_h];

  if_fetch_stage #(.WRAP(1'b1)) dut_w (
    .clk(clk), .rstn(rstn), .en(en), .freeze_i(freeze_i),
    .redir_valid(redir_valid), .redir_pc(redir_pc),
    .imem_addr(addr_w), .imem_rdata(rdata_w),
    .out_valid(valid_w), .out_ready(out_ready), .out_inst(inst_w), .out_pc(opc_w),
    .halted(halt_w), .misalign_o(mis_w), .fetch_cnt(cnt_w)
  );

  if_fetch_stage #(.WRAP(1'b0)) dut_h (
    .clk(clk), .rstn(rstn), .en(en), .freeze_i(freeze_i),
    .redir_valid(redir_valid), .redir_pc(redir_pc),
    .imem_addr(addr_h), .imem_rdata(rdata_h),
    .out_valid(valid_h), .out_ready(out_ready), .out_inst(inst_h), .out_pc(opc_h),
    .halted(halt_h), .misalign_o(mis_h), .fetch_cnt(cnt_h)
  );

  // Reference: mode 0=running, 1=frozen, 2=halted; index 0 wraps, index 1 halts.
  logic [31:0] m_pc [2], m_inst [2], m_opc [2], m_cnt [2];
  int          m_mode [2];
  bit          m_v [2], m_mis [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (!rstn) begin
        m_pc[k] = 0; m_mode[k] = 0; m_v[k] = 0; m_inst[k] = 32'h13;
        m_opc[k] = 0; m_cnt[k] = 0; m_mis[k] = 0;
      end else if (!en) begin
        m_mis[k] = 0;
      end else if (redir_valid) begin
        m_mis[k]  = (redir_pc % 4) != 0;
        m_pc[k]   = redir_pc - (redir_pc % 4);
        m_v[k]    = 0;
        m_mode[k] = freeze_i ? 1 : 0;
      end else begin
        m_mis[k] = 0;
        if (m_mode[k] == 0 && (!m_v[k] || out_ready)) begin
          m_inst[k] = rom[(m_pc[k] / 4) % 64];
          m_opc[k]  = m_pc[k];
          m_v[k]    = 1;
          m_cnt[k]  = m_cnt[k] + 1;
          if (freeze_i) m_mode[k] = 1;
          if (m_pc[k] == 44) begin
            if (k == 0) m_pc[k] = 0;
            else        m_mode[k] = 2;
          end else begin
            m_pc[k] = m_pc[k] + 4;
          end
        end else begin
          if (m_v[k] && out_ready) m_v[k] = 0;
          if (m_mode[k] == 0 && freeze_i)       m_mode[k] = 1;
          else if (m_mode[k] == 1 && !freeze_i) m_mode[k] = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("w.valid", 32'(valid_w), 32'(m_v[0]));
    chk("w.inst",  inst_w,       m_inst[0]);
    chk("w.pc",    opc_w,        m_opc[0]);
    chk("w.cnt",   cnt_w,        m_cnt[0]);
    chk("w.halt",  32'(halt_w),  32'(m_mode[0] == 2));
    chk("w.mis",   32'(mis_w),   32'(m_mis[0]));
    chk("w.addr",  32'(addr_w),  (m_pc[0] / 4) % 64);
    chk("h.valid", 32'(valid_h), 32'(m_v[1]));
    chk("h.inst",  inst_h,       m_inst[1]);
    chk("h.pc",    opc_h,        m_opc[1]);
    chk("h.cnt",   cnt_h,        m_cnt[1]);
    chk("h.halt",  32'(halt_h),  32'(m_mode[1] == 2));
    chk("h.mis",   32'(mis_h),   32'(m_mis[1]));
    chk("h.addr",  32'(addr_h),  (m_pc[1] / 4) % 64);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'h100 + i;
    rstn = 0; en = 1; freeze_i = 0; redir_valid = 0; redir_pc = 0; out_ready = 1;
    step(); step();
    chk("rst.inst", inst_w, 32'h00000013);
    chk("rst.cnt", cnt_w, 0);
    chk("rst.valid", 32'(valid_w), 0);

    rstn = 1;
    repeat (12) step();
    chk("seq.cnt12", cnt_w, 12);
    chk("seq.lastpc", opc_w, 32'd44);
    chk("seq.lastinst", inst_w, 32'h10B);
    chk("seq.wrapaddr", 32'(addr_w), 0);
    chk("halt.set", 32'(halt_h), 1);
    chk("halt.addr", 32'(addr_h), 11);
    step();
    chk("halt.drain", 32'(valid_h), 0);
    chk("wrap.pc0", opc_w, 0);
    redir_valid = 1; redir_pc = 32'h8;
    step();
    chk("halt.clear", 32'(halt_h), 0);
    redir_valid = 0;
    step();
    chk("redir.h.pc", opc_h, 32'h8);
    chk("redir.w.pc", opc_w, 32'h8);

    redir_valid = 1; redir_pc = 32'h1E;
    step();
    chk("mis.flush", 32'(valid_w), 0);
    chk("mis.pulse", 32'(mis_w), 1);
    redir_valid = 0;
    step();
    chk("mis.pc", opc_w, 32'h1C);
    chk("mis.clear", 32'(mis_w), 0);

    out_ready = 0; repeat (3) step();
    out_ready = 1; repeat (2) step();

    freeze_i = 1; repeat (3) step();
    redir_valid = 1; redir_pc = 32'h20; step();
    redir_valid = 0; repeat (2) step();
    freeze_i = 0; repeat (4) step();

    en = 0; rstn = 0; step();
    rstn = 1;
    for (int i = 0; i < 6; i++) begin
      en = (i % 2 == 0);
      step();
    end
    en = 1;

    for (int n = 0; n < 3000; n++) begin
      rstn        = ($urandom_range(0, 199) != 0);
      en          = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 11) == 0) freeze_i = ~freeze_i;
      redir_valid = ($urandom_range(0, 9) == 0);
      redir_pc    = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 63));
      out_ready   = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
